// File: rtl/param_def.sv
// Definitions shared by the convolutional encoder and the Viterbi decoder blocks:
// code geometry limits and the frame-control state encoding.
package param_def;
    localparam int MAX_K         = 9;
    localparam int MAX_STATE_NUM = 1 << (MAX_K - 1);
    localparam int RADIX         = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_DONE
    } enc_state_e;
endpackage

// File: rtl/conv_parity.sv
// One generator output: XOR-reduction of the encoder window masked by its polynomial.
module conv_parity #(
    parameter int WIN_W = 9
) (
    input  logic [WIN_W-1:0] i_win,
    input  logic [WIN_W-1:0] i_gen,
    output logic             o_parity
);
    assign o_parity = ^(i_win & i_gen);
endmodule

// File: rtl/conv_encoder.sv
// Frame-based convolutional encoder, K = 3..9, rate 1/2 or 1/3, zero-tail termination,
// one registered codeword per information bit with valid/ready backpressure.
module conv_encoder #(
    parameter int MAX_K = param_def::MAX_K,
    parameter int N_OUT = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [3:0]                      i_cfg_k,
    input  logic                            i_cfg_rate,
    input  logic [N_OUT-1:0][MAX_K-1:0]     i_gen,
    input  logic [15:0]                     i_frame_len,
    input  logic                            i_bit,
    input  logic                            i_bit_valid,
    output logic                            o_bit_ready,
    output logic [N_OUT-1:0]                o_sym,
    output logic                            o_sym_valid,
    input  logic                            i_sym_ready,
    output logic                            o_busy,
    output logic                            o_done
);
    import param_def::*;

    enc_state_e                  state_q, state_d;
    logic [3:0]                  k_q;
    logic                        rate_q;
    logic [N_OUT-1:0][MAX_K-1:0] gen_q;
    logic [15:0]                 len_q;
    logic [15:0]                 cnt_q;
    logic [MAX_K-1:0]            hist_q;
    logic [MAX_K-1:0]            win;
    logic [N_OUT-1:0]            par;
    logic [N_OUT-1:0]            sym_p1;
    logic                        vld_p1;
    logic                        cfg_ok;
    logic                        start_ok;
    logic                        out_free;
    logic                        accept;
    logic                        tail_all;
    logic                        tail_fire;
    logic                        cur_bit;

    // Rate 1/2 frames drive only the first two generator outputs.
    function automatic logic [N_OUT-1:0] rate_mask(input logic [N_OUT-1:0] p, input logic r);
        logic [N_OUT-1:0] m;
        m = p;
        if (!r) begin
            for (int j = 2; j < N_OUT; j++) m[j] = 1'b0;
        end
        return m;
    endfunction

    assign cfg_ok    = (i_cfg_k >= 4'd3) && (i_cfg_k <= 4'd9) && (int'(i_cfg_k) <= MAX_K);
    assign start_ok  = (state_q == ST_IDLE) && i_start && cfg_ok;
    assign out_free  = !vld_p1 || i_sym_ready;
    assign accept    = i_bit_valid && o_bit_ready;
    assign tail_all  = (cnt_q == ({12'd0, k_q} - 16'd1));
    assign tail_fire = (state_q == ST_TAIL) && out_free && !tail_all;
    assign cur_bit   = accept & i_bit;

    // hist_q[K-2:0] holds the previous K-1 inputs, newest in the top position, so the
    // window is just the current bit placed at K-1 and the next history is win >> 1.
    assign win = hist_q | ({{(MAX_K-1){1'b0}}, cur_bit} << (k_q - 4'd1));

    for (genvar j = 0; j < N_OUT; j++) begin : g_par
        conv_parity #(.WIN_W(MAX_K)) u_parity (
            .i_win    (win),
            .i_gen    (gen_q[j]),
            .o_parity (par[j])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = (i_frame_len == 16'd0) ? ST_TAIL : ST_DATA;
            ST_DATA: if (accept && ((cnt_q + 16'd1) == len_q)) state_d = ST_TAIL;
            ST_TAIL: if (tail_all && vld_p1 && i_sym_ready) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // p0 -> p1: window parity is registered as the outgoing codeword
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q    <= '0;
            rate_q <= 1'b0;
            gen_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            hist_q <= '0;
            sym_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (start_ok) begin
                k_q    <= i_cfg_k;
                rate_q <= i_cfg_rate;
                gen_q  <= i_gen;
                len_q  <= i_frame_len;
                cnt_q  <= '0;
                hist_q <= '0;
            end else if (accept) begin
                hist_q <= win >> 1;
                cnt_q  <= (state_d == ST_TAIL) ? 16'd0 : cnt_q + 16'd1;
            end else if (tail_fire) begin
                hist_q <= win >> 1;
                cnt_q  <= cnt_q + 16'd1;
            end

            if (accept || tail_fire) begin
                sym_p1 <= rate_mask(par, rate_q);
                vld_p1 <= 1'b1;
            end else if (i_sym_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign o_bit_ready = (state_q == ST_DATA) && out_free;
    assign o_sym       = sym_p1;
    assign o_sym_valid = vld_p1;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
endmodule
